// File: rtl/decode_writeback_pkg.sv
// Y86-64 definitions shared by the decode/write-back slice: instruction
// codes, register ids and the default operand width.
package decode_writeback_pkg;

  localparam int DATA_W_DEF = 64;

  // Instruction codes as produced by fetch
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register ids
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/decode_writeback_regfile_2r2w.sv
// Program register file: two combinational operand read ports plus a
// combinational debug port, two synchronous write ports (E and M) where M
// wins on a shared destination, and an asynchronous active-low clear.
// Any id at or above NREGS reads as zero and is never written.
module decode_writeback_regfile_2r2w #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        raddr_a_i,
  input  logic [3:0]        raddr_b_i,
  input  logic [3:0]        raddr_dbg_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [DATA_W-1:0] rdata_dbg_o,
  input  logic              we_e_i,
  input  logic [3:0]        waddr_e_i,
  input  logic [DATA_W-1:0] wdata_e_i,
  input  logic              we_m_i,
  input  logic [3:0]        waddr_m_i,
  input  logic [DATA_W-1:0] wdata_m_i
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Next-state per register: the M port is checked first so popq %rsp keeps valM
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we_m_i && (int'(waddr_m_i) == i)) begin
        regs_d[i] = wdata_m_i;
      end else if (we_e_i && (int'(waddr_e_i) == i)) begin
        regs_d[i] = wdata_e_i;
      end
    end
  end

  // Register storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports return pre-edge contents; unmatched ids (>= NREGS) read zero
  always_comb begin
    rdata_a_o   = '0;
    rdata_b_o   = '0;
    rdata_dbg_o = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (int'(raddr_a_i) == i)   rdata_a_o   = regs_q[i];
      if (int'(raddr_b_i) == i)   rdata_b_o   = regs_q[i];
      if (int'(raddr_dbg_i) == i) rdata_dbg_o = regs_q[i];
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// SEQ decode and write-back stage. Selects source/destination register ids
// from the fetched instruction, reads operands combinationally and commits
// valE/valM into the register file at the edge that ends the cycle.
module decode_writeback
  import decode_writeback_pkg::*;
#(
  parameter int         DATA_W = DATA_W_DEF,
  parameter int         NREGS  = 15,
  parameter logic [3:0] RSP_ID = RSP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              wb_en,
  input  logic              stat_ok,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  input  logic [3:0]        dbg_id,
  output logic [DATA_W-1:0] dbg_val
);

  logic commit;
  logic we_e;
  logic we_m;

  // Source and destination selection by instruction class
  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      I_RRMOVQ: begin
        srcA = rA;
        dstE = cnd ? rB : RNONE;
      end
      I_IRMOVQ: dstE = rB;
      I_RMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      I_OPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = RSP_ID;
        dstE = RSP_ID;
      end
      I_RET: begin
        srcA = RSP_ID;
        srcB = RSP_ID;
        dstE = RSP_ID;
      end
      I_PUSHQ: begin
        srcA = rA;
        srcB = RSP_ID;
        dstE = RSP_ID;
      end
      I_POPQ: begin
        srcA = RSP_ID;
        srcB = RSP_ID;
        dstE = RSP_ID;
        dstM = rA;
      end
      default: ;
    endcase
  end

  // A faulting or halted instruction must leave architectural state untouched
  assign commit = wb_en && stat_ok;
  assign we_e   = commit && (dstE != RNONE);
  assign we_m   = commit && (dstM != RNONE);

  decode_writeback_regfile_2r2w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .raddr_a_i   (srcA),
    .raddr_b_i   (srcB),
    .raddr_dbg_i (dbg_id),
    .rdata_a_o   (valA),
    .rdata_b_o   (valB),
    .rdata_dbg_o (dbg_val),
    .we_e_i      (we_e),
    .waddr_e_i   (dstE),
    .wdata_e_i   (valE),
    .we_m_i      (we_m),
    .waddr_m_i   (dstM),
    .wdata_m_i   (valM)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: operand selection, write-back,
// gating, M-over-E priority and asynchronous reset.
module tb_decode_writeback;

  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic [3:0]    icode;
  logic [3:0]    rA;
  logic [3:0]    rB;
  logic          cnd;
  logic [DW-1:0] valE;
  logic [DW-1:0] valM;
  logic          wb_en;
  logic          stat_ok;
  logic [DW-1:0] valA;
  logic [DW-1:0] valB;
  logic [3:0]    srcA;
  logic [3:0]    srcB;
  logic [3:0]    dstE;
  logic [3:0]    dstM;
  logic [3:0]    dbg_id;
  logic [DW-1:0] dbg_val;

  int n_checks = 0;
  int n_errors = 0;

  decode_writeback dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .icode   (icode),
    .rA      (rA),
    .rB      (rB),
    .cnd     (cnd),
    .valE    (valE),
    .valM    (valM),
    .wb_en   (wb_en),
    .stat_ok (stat_ok),
    .valA    (valA),
    .valB    (valB),
    .srcA    (srcA),
    .srcB    (srcB),
    .dstE    (dstE),
    .dstM    (dstM),
    .dbg_id  (dbg_id),
    .dbg_val (dbg_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    check(tag, {60'd0, obs}, {60'd0, exp});
  endtask

  task automatic rd_dbg(input logic [3:0] id, output logic [63:0] v);
    dbg_id = id;
    #1;
    v = dbg_val;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m);
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
    #1;
  endtask

  initial begin
    logic [63:0] v;
    rst_n = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    valE = '0; valM = '0; wb_en = 1'b0; stat_ok = 1'b1; dbg_id = 4'h0;
    #2;
    rd_dbg(4'h0, v);  check("reset_r0", v, 64'h0);
    rd_dbg(4'hE, v);  check("reset_r14", v, 64'h0);
    rd_dbg(4'hF, v);  check("reset_rnone", v, 64'h0);
    step();
    rst_n = 1'b1;
    wb_en = 1'b1;

    // irmovq $0x1234, %rdx
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0);
    check_id("irmovq_dstE", dstE, 4'h2);
    check_id("irmovq_dstM", dstM, 4'hF);
    check_id("irmovq_srcA", srcA, 4'hF);
    rd_dbg(4'h2, v);  check("irmovq_pre_edge", v, 64'h0);
    step();
    rd_dbg(4'h2, v);  check("irmovq_r2", v, 64'h1234);

    // irmovq $0x11, %rcx
    drive(4'h3, 4'hF, 4'h1, 1'b0, 64'h11, 64'h0);
    step();

    // addq %rcx, %rdx: operands are pre-edge values, result visible after edge
    drive(4'h6, 4'h1, 4'h2, 1'b0, 64'h1245, 64'h0);
    check_id("opq_srcA", srcA, 4'h1);
    check_id("opq_srcB", srcB, 4'h2);
    check_id("opq_dstE", dstE, 4'h2);
    check("opq_valA", valA, 64'h11);
    check("opq_valB", valB, 64'h1234);
    step();
    check("opq_valB_after", valB, 64'h1245);

    // cmovXX not taken, then taken
    drive(4'h2, 4'h1, 4'h3, 1'b0, 64'h7, 64'h0);
    check_id("cmov_nt_dstE", dstE, 4'hF);
    step();
    rd_dbg(4'h3, v);  check("cmov_nt_r3", v, 64'h0);
    drive(4'h2, 4'h1, 4'h3, 1'b1, 64'h7, 64'h0);
    check_id("cmov_t_dstE", dstE, 4'h3);
    step();
    rd_dbg(4'h3, v);  check("cmov_t_r3", v, 64'h7);

    // popq %rsp: M wins
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h8, 64'hAA);
    check_id("popq_dstE", dstE, 4'h4);
    check_id("popq_dstM", dstM, 4'h4);
    check_id("popq_srcA", srcA, 4'h4);
    check_id("popq_srcB", srcB, 4'h4);
    step();
    rd_dbg(4'h4, v);  check("popq_rsp_r4", v, 64'hAA);

    // popq %rbp: both ports write different registers
    drive(4'hB, 4'h5, 4'hF, 1'b0, 64'h10, 64'hBB);
    check("popq_valA_rsp", valA, 64'hAA);
    step();
    rd_dbg(4'h4, v);  check("popq_r4", v, 64'h10);
    rd_dbg(4'h5, v);  check("popq_r5", v, 64'hBB);

    // Selection for the remaining classes
    drive(4'hA, 4'h3, 4'hF, 1'b0, 64'h0, 64'h0);
    wb_en = 1'b0; #1;
    check_id("pushq_srcA", srcA, 4'h3);
    check_id("pushq_srcB", srcB, 4'h4);
    check_id("pushq_dstE", dstE, 4'h4);
    drive(4'h8, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    check_id("call_srcA", srcA, 4'hF);
    check_id("call_srcB", srcB, 4'h4);
    drive(4'h9, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    check_id("ret_srcA", srcA, 4'h4);
    check_id("ret_dstM", dstM, 4'hF);
    drive(4'h5, 4'h6, 4'h1, 1'b0, 64'h0, 64'h0);
    check_id("mrmovq_srcB", srcB, 4'h1);
    check_id("mrmovq_dstM", dstM, 4'h6);
    check_id("mrmovq_dstE", dstE, 4'hF);
    drive(4'h4, 4'h2, 4'h3, 1'b0, 64'h0, 64'h0);
    check_id("rmmovq_srcA", srcA, 4'h2);
    check_id("rmmovq_dstE", dstE, 4'hF);
    drive(4'h0, 4'h2, 4'h3, 1'b1, 64'h0, 64'h0);
    check_id("halt_srcA", srcA, 4'hF);
    check_id("halt_dstE", dstE, 4'hF);

    // Gating: wb_en low, then stat_ok low
    drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h99, 64'h0);
    step();
    rd_dbg(4'h6, v);  check("gate_wben_r6", v, 64'h0);
    wb_en = 1'b1; stat_ok = 1'b0;
    step();
    rd_dbg(4'h6, v);  check("gate_stat_r6", v, 64'h0);
    stat_ok = 1'b1;

    // OPq with no registers reads zero
    wb_en = 1'b0;
    drive(4'h6, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    check("opq_none_valA", valA, 64'h0);
    check("opq_none_valB", valB, 64'h0);

    // Highest register id
    wb_en = 1'b1;
    drive(4'h3, 4'hF, 4'hE, 1'b0, 64'hEE, 64'h0);
    step();
    rd_dbg(4'hE, v);  check("r14_write", v, 64'hEE);

    // Mid-cycle reset clears everything without a clock, then writes resume
    drive(4'h3, 4'hF, 4'h7, 1'b0, 64'h77, 64'h0);
    rst_n = 1'b0;
    rd_dbg(4'h2, v);  check("midrst_r2", v, 64'h0);
    rd_dbg(4'h4, v);  check("midrst_r4", v, 64'h0);
    rd_dbg(4'hE, v);  check("midrst_r14", v, 64'h0);
    rst_n = 1'b1;
    #1;
    rd_dbg(4'h7, v);  check("midrst_r7_pre", v, 64'h0);
    step();
    rd_dbg(4'h7, v);  check("postrst_r7", v, 64'h77);
    rd_dbg(4'h2, v);  check("postrst_r2", v, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
